// File: rtl/ohs_pwm_l2.sv
// Multi-channel PWM: one edge/center-aligned carrier, per-channel compare, shadow registers loaded at period boundary.
// Optional feature macro OHS_PWM_DEADTIME_EN adds dead_time input, complementary pwm_n outputs and dead-time insertion.
module ohs_pwm_l2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_CH       = 4
) (
    input  logic                       aclk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       center_mode,
    input  logic [DATA_WIDTH-1:0]      pwm_period,
    input  logic [N_CH*DATA_WIDTH-1:0] pwm_comparator,
    input  logic                       update_req,
`ifdef OHS_PWM_DEADTIME_EN
    input  logic [7:0]                 dead_time,
    output logic [N_CH-1:0]            pwm_n,
`endif
    output logic                       update_done,
    output logic [DATA_WIDTH-1:0]      pwm_counter,
    output logic                       period_end,
    output logic [N_CH-1:0]            pwm
);
    localparam int unsigned DW = DATA_WIDTH;

    logic [DW-1:0]           cnt_q, cnt_d;
    logic                    dir_q, dir_d;   // 1: counting down
    logic [DW-1:0]           p_sh;
    logic [N_CH-1:0][DW-1:0] c_sh;
    logic                    mode_sh;
    logic                    pending_q;
    logic                    boundary_c, load_c, restart_c, down_phase_c;
    logic [N_CH-1:0]         raw_d, raw_q;

    // Boundary: wrap cycle (edge), counter zero (center), or every cycle when idle / P=0
    always_comb begin
        boundary_c = 1'b0;
        if (!enable || (p_sh == '0)) begin
            boundary_c = 1'b1;
        end else if (mode_sh) begin
            boundary_c = (cnt_q == '0);
        end else begin
            boundary_c = (cnt_q >= p_sh);
        end
    end

    assign load_c    = boundary_c && (pending_q || update_req);
    assign restart_c = !enable || (load_c && (center_mode != mode_sh));

    // Carrier next state; out-of-range counts (after P was lowered) wrap to 0
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (restart_c || (p_sh == '0)) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (!mode_sh) begin
            cnt_d = (cnt_q >= p_sh) ? '0 : cnt_q + DW'(1);
            dir_d = 1'b0;
        end else if (cnt_q > p_sh) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (!dir_q) begin
            if (cnt_q == p_sh) begin
                cnt_d = cnt_q - DW'(1);
                dir_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end else begin
            if (cnt_q == '0) begin
                cnt_d = DW'(1);
                dir_d = 1'b0;
            end else begin
                cnt_d = cnt_q - DW'(1);
            end
        end
    end

    // Falling slope of the triangle uses <= so a center pulse spans 2*C cycles around zero
    assign down_phase_c = mode_sh && dir_q && (cnt_q != '0);

    always_comb begin
        raw_d = '0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            if (down_phase_c) begin
                raw_d[ch] = enable && (cnt_q <= c_sh[ch]);
            end else begin
                raw_d[ch] = enable && (cnt_q < c_sh[ch]);
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            p_sh        <= '0;
            c_sh        <= '0;
            mode_sh     <= 1'b0;
            pending_q   <= 1'b0;
            raw_q       <= '0;
            period_end  <= 1'b0;
            update_done <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            raw_q       <= raw_d;
            period_end  <= enable && boundary_c;
            update_done <= load_c;
            pending_q   <= !load_c && (pending_q || update_req);
            if (load_c) begin
                p_sh    <= pwm_period;
                c_sh    <= pwm_comparator;
                mode_sh <= center_mode;
            end
        end
    end

    assign pwm_counter = cnt_q;

`ifdef OHS_PWM_DEADTIME_EN
    logic [N_CH-1:0][7:0] dt_q, dt_d;
    logic [N_CH-1:0]      pwm_d, pwm_n_d;

    // Any change of the raw compare restarts the dead window; both outputs stay low until it expires
    always_comb begin
        dt_d    = dt_q;
        pwm_d   = '0;
        pwm_n_d = '0;
        for (int ch = 0; ch < int'(N_CH); ch++) begin
            if (raw_d[ch] != raw_q[ch]) begin
                dt_d[ch] = dead_time;
            end else if (dt_q[ch] != 8'd0) begin
                dt_d[ch] = dt_q[ch] - 8'd1;
            end
            pwm_d[ch]   = (dt_d[ch] == 8'd0) && raw_d[ch];
            pwm_n_d[ch] = (dt_d[ch] == 8'd0) && !raw_d[ch] && enable;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            dt_q  <= '0;
            pwm   <= '0;
            pwm_n <= '0;
        end else begin
            dt_q  <= dt_d;
            pwm   <= pwm_d;
            pwm_n <= pwm_n_d;
        end
    end
`else
    assign pwm = raw_q;
`endif

endmodule
